// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix operand loader.
package matrix_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    L_IDLE  = 2'b00,
    L_FETCH = 2'b01,
    L_DONE  = 2'b11
  } load_state_e;
endpackage

// File: rtl/loader_fifo.sv
// Circular-buffer sync FIFO; full/empty are registered from the post-edge count.
module loader_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/matrix_loader.sv
// Operand loader: buffers APB writes, assembles a ROWS-element column on load_en,
// and rotates it during the controller's shift phase.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [DATA_W-1:0]      pwdata,
  input  logic                   pready_in,
  input  logic                   load_en,
  input  logic                   shift_data_en,
  output logic                   load_done,
  output logic [ROWS*DATA_W-1:0] col_data,
  output logic                   col_valid,
  output logic                   buf_full,
  output logic                   buf_empty,
  output logic                   overflow_err,
  output load_state_e            state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(ROWS);
  localparam logic [AW:0]   ROWS_CNT = (AW+1)'(ROWS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS-1);

  load_state_e       state;
  load_state_e       state_nxt;
  logic              wr_req;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;
  logic [AW:0]       fifo_count;
  logic [IW-1:0]     fetch_idx;
  logic [IW-1:0]     shift_cnt;
  logic              shift_ok;
  logic              fetch_start;

  // Write handshake: a beat transfers when psel, penable, pwrite and pready_in are all
  // high at the clock edge; it is stored only if the FIFO was not already full.
  assign wr_req = psel & penable & pwrite & pready_in;
  assign push   = wr_req & ~buf_full;

  loader_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pwdata),
    .dout  (fifo_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= L_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    fetch_start = 1'b0;
    case (state)
      L_IDLE: begin
        if (load_en && fifo_count >= ROWS_CNT) begin
          state_nxt   = L_FETCH;
          fetch_start = 1'b1;
        end
      end
      L_FETCH: begin
        pop = 1'b1;
        if (fetch_idx == LAST_IDX) state_nxt = L_DONE;
      end
      L_DONE:  state_nxt = L_IDLE;
      default: state_nxt = L_IDLE;
    endcase
  end

  assign shift_ok  = shift_data_en & col_valid & (state == L_IDLE);
  assign load_done = (state == L_DONE) | (shift_ok & (shift_cnt == LAST_IDX));
  assign state_dbg = state;

  // col_valid rises on the last fetch edge so it is already high in the L_DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_data     <= '0;
      col_valid    <= 1'b0;
      shift_cnt    <= '0;
      fetch_idx    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_req && buf_full) overflow_err <= 1'b1;
      if (fetch_start) begin
        col_valid <= 1'b0;
        fetch_idx <= '0;
      end else if (shift_ok) begin
        col_data  <= {col_data[DATA_W-1:0], col_data[ROWS*DATA_W-1:DATA_W]};
        shift_cnt <= shift_cnt + 1'b1;
        if (shift_cnt == LAST_IDX) col_valid <= 1'b0;
      end
      if (state == L_FETCH) begin
        col_data[fetch_idx*DATA_W +: DATA_W] <= fifo_dout;
        fetch_idx <= fetch_idx + 1'b1;
        if (fetch_idx == LAST_IDX) begin
          col_valid <= 1'b1;
          shift_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: load latency, stall, shift rotation, overflow,
// concurrent fill/fetch across pointer wrap, and reset mid-fetch.
module tb_matrix_loader;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  pwdata = '0;
  logic        pready_in = 1'b1;
  logic        load_en = 1'b0;
  logic        shift_data_en = 1'b0;
  logic        load_done;
  logic [31:0] col_data;
  logic        col_valid;
  logic        buf_full;
  logic        buf_empty;
  logic        overflow_err;
  load_state_e state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_loader #(.DATA_W(8), .ROWS(4), .DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .pwdata        (pwdata),
    .pready_in     (pready_in),
    .load_en       (load_en),
    .shift_data_en (shift_data_en),
    .load_done     (load_done),
    .col_data      (col_data),
    .col_valid     (col_valid),
    .buf_full      (buf_full),
    .buf_empty     (buf_empty),
    .overflow_err  (overflow_err),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] d);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; pwdata = d;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    lat = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      if (load_done) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  task automatic do_load(input logic [31:0] exp_col);
    int lat;
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    wait_done(12, lat);
    check("load_latency", lat, 5);
    check("load_col", col_data, exp_col);
    check("load_valid", col_valid, 1);
    tick();
    check("done_pulse_end", load_done, 0);
  endtask

  initial begin
    logic [31:0] shift_exp [4];
    logic        seen;
    shift_exp[0] = 32'h11443322;
    shift_exp[1] = 32'h22114433;
    shift_exp[2] = 32'h33221144;
    shift_exp[3] = 32'h44332211;

    // reset values
    #12;
    check("rst_load_done", load_done, 0);
    check("rst_col_data", col_data, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_full", buf_full, 0);
    check("rst_empty", buf_empty, 1);
    check("rst_ovf", overflow_err, 0);
    check("rst_state", state_dbg, L_IDLE);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // write blocked while pready_in low
    pready_in = 1'b0;
    apb_write(8'hEE);
    pready_in = 1'b1;
    check("no_pready_empty", buf_empty, 1);

    // basic load
    apb_write(8'h11); apb_write(8'h22); apb_write(8'h33); apb_write(8'h44);
    check("four_written_empty", buf_empty, 0);
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    begin
      int lat;
      wait_done(12, lat);
      check("t1_latency", lat, 5);
    end
    check("t1_col", col_data, 32'h44332211);
    check("t1_valid", col_valid, 1);
    check("t1_empty", buf_empty, 1);
    tick();
    check("t1_done_pulse", load_done, 0);

    // shift rotation and exhaustion
    for (int i = 0; i < 4; i++) begin
      shift_data_en = 1'b1;
      #1;
      check("shift_done", load_done, (i == 3));
      tick();
      shift_data_en = 1'b0;
      check("shift_col", col_data, shift_exp[i]);
      check("shift_valid", col_valid, (i < 3));
    end
    shift_data_en = 1'b1;
    #1;
    check("shift_novalid_done", load_done, 0);
    tick();
    shift_data_en = 1'b0;
    check("shift_novalid_col", col_data, 32'h44332211);

    // stall with 3 elements
    apb_write(8'hA1); apb_write(8'hA2); apb_write(8'hA3);
    load_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (load_done) seen = 1'b1;
      tick();
    end
    check("stall_no_done", seen, 0);
    check("stall_state", state_dbg, L_IDLE);
    apb_write(8'hA4);
    do_load(32'hA4A3A2A1);

    // overflow
    for (int i = 0; i < 16; i++) apb_write(8'(8'h50 + i));
    check("ovf_full16", buf_full, 1);
    check("ovf_not_yet", overflow_err, 0);
    apb_write(8'h60);
    check("ovf_set", overflow_err, 1);
    do_load(32'h53525150);
    check("ovf_sticky", overflow_err, 1);
    check("ovf_not_full", buf_full, 0);

    // fill to 16 then fetch while writing every cycle
    for (int i = 0; i < 4; i++) apb_write(8'(8'hC0 + i));
    check("fill_full", buf_full, 1);
    load_en = 1'b1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pwdata = 8'(8'h70 + k);
      tick();
      load_en = 1'b0;
      check("cw_full", buf_full, (k == 0));
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("cw_done", load_done, 1);
    check("cw_col", col_data, 32'h57565554);
    tick();
    do_load(32'h5B5A5958);
    do_load(32'h5F5E5D5C);
    do_load(32'hC3C2C1C0);
    check("cw_left", buf_empty, 0);
    apb_write(8'h75);
    do_load(32'h75747372);
    check("cw_drained", buf_empty, 1);

    // reset in second fetch cycle
    apb_write(8'h81); apb_write(8'h82); apb_write(8'h83); apb_write(8'h84);
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    check("mid_fetch_state", state_dbg, L_FETCH);
    rst = 1'b0;
    #2;
    check("ar_load_done", load_done, 0);
    check("ar_col", col_data, 0);
    check("ar_valid", col_valid, 0);
    check("ar_empty", buf_empty, 1);
    check("ar_full", buf_full, 0);
    check("ar_ovf", overflow_err, 0);
    check("ar_state", state_dbg, L_IDLE);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ar_post_empty", buf_empty, 1);
    apb_write(8'h91); apb_write(8'h92); apb_write(8'h93); apb_write(8'h94);
    do_load(32'h94939291);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
# matrix_loader

Operand-side responder for the matrix controller's load handshake. Accepts matrix elements over an APB-style write port into a FIFO. When the controller raises `load_en`, it assembles one full column of `ROWS` elements and answers with a `load_done` pulse. During the controller's shift phase it rotates the column and reports column exhaustion, also via `load_done`.

## Interface
- `DATA_W`, 8: element width in bits.
- `ROWS`, 4: elements per column (power of two, ≥2).
- `DEPTH`, 16: FIFO entries (power of two, ≥ROWS).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `psel`, `penable`, `pwrite`  in  1 each  APB write qualifiers.
- `pwdata`  in  DATA_W  element to push.
- `pready_in`  in  1  controller's `pready`; writes are accepted only while high.
- `load_en`  in  1  controller requests a column.
- `shift_data_en`  in  1  controller shift phase, one cycle per assertion.
- `load_done`  out  1  column loaded, or column exhausted on shift.
- `col_data`  out  ROWS*DATA_W  current column; element 0 in bits [DATA_W-1:0].
- `col_valid`  out  1  `col_data` holds a complete column.
- `buf_full`, `buf_empty`  out  1 each  FIFO status.
- `overflow_err`  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- Push when `psel & penable & pwrite & pready_in & !buf_full`.
- If `buf_full` at an otherwise valid write, the data is dropped and `overflow_err` is set. `overflow_err` clears only on reset.
- FIFO is a circular buffer with log2(DEPTH)-bit pointers and a log2(DEPTH)+1-bit occupancy count. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: both take effect and the count is unchanged.
- FSM states:
  - `L_IDLE`: go to `L_FETCH` when `load_en` is high and count ≥ ROWS. Otherwise stay; this is the stall, and `load_done` stays low.
  - `L_FETCH`: pop one element per cycle into column slot `fetch_idx` (0..ROWS-1). After slot ROWS-1, go to `L_DONE`. `load_en` is ignored here; fetch always completes.
  - `L_DONE`: `load_done` = 1 for exactly this cycle. Set `col_valid` and clear `shift_cnt`. Return to `L_IDLE`.
- `col_valid` clears on entry to `L_FETCH`.
- Shift: on `shift_data_en` in `L_IDLE` with `col_valid`:
  - rotate `col_data` right by DATA_W; element 0 moves to the top slot;
  - `shift_cnt` increments modulo ROWS.
- `load_done` is combinational: `(state==L_DONE) | (shift_data_en & col_valid & shift_cnt==ROWS-1)`.
  - On that exhausting shift, `col_valid` clears the next cycle.
- `shift_data_en` outside `L_IDLE`, or with `col_valid` low, is ignored and gives no `load_done`.

## Timing
- Reset values: `load_done`=0, `col_data`=0, `col_valid`=0, `buf_full`=0, `buf_empty`=1, `overflow_err`=0, FSM=`L_IDLE`, all pointers and counters 0.
- Reset asserted mid-fetch or mid-shift aborts immediately. No partial column survives.
- Load latency: `load_en` sampled high at edge t (count ≥ ROWS):
  - `L_FETCH` occupies cycles t+1..t+ROWS;
  - `load_done` is high in cycle t+ROWS+1, i.e. 5 cycles for ROWS=4.
- Write-to-available: a pushed element is poppable in the cycle after the accepting edge.
- `buf_full`/`buf_empty` are registered and reflect count after the edge.
- Write and fetch in the same cycle on a full FIFO: the pop frees a slot only at that edge, so the write is still dropped (`buf_full` was high).

## Structure
- Shared package (`matrix_pkg`):
  - FSM state encodings `L_IDLE`=2'b00, `L_FETCH`=2'b01, `L_DONE`=2'b11;
  - default `DATA_W`/`ROWS`.
- Sub-module `loader_fifo`: parameterised sync FIFO exposing push, pop, dout, full, empty, count.
- Top holds the FSM, column register, shift counter and error flag.

## Test plan
- Write 4 elements 0x11,0x22,0x33,0x44, then pulse `load_en` → `load_done` high exactly 5 cycles later, `col_data`=0x44332211, `col_valid`=1, `buf_empty`=1.
- Write 3 elements, hold `load_en` → no `load_done` for 20 cycles. Write a 4th → `load_done` 5 cycles after the next `load_en` sample.
- After a loaded column 0x44332211, apply 4 `shift_data_en` pulses → `col_data` 0x11443322, 0x22114433, 0x33221144. `load_done` only on the 4th pulse, and `col_valid`=0 the cycle after.
- Write 17 elements with DEPTH=16 and no pops → `buf_full`=1 after the 16th, 17th dropped, `overflow_err`=1 and stays set through a later load.
- Fill to 16, fetch while writing every cycle → count never exceeds 16, writes are accepted from the cycle after the first pop, and data order is preserved across pointer wrap.
- Assert `rst` in the 2nd `L_FETCH` cycle → all outputs at reset values next cycle. Reload with 4 new elements gives a correct column.
